// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath: sequencer state encoding
// and the default accumulation-pass length.
package nn_pkg;

  localparam int N_READS_DEFAULT = 8;

  // One-hot so the AG and ALU benches can decode a state with a single bit test.
  typedef enum logic [4:0] {
    S_RST    = 5'b00001,
    S_CLR    = 5'b00010,
    S_READ   = 5'b00100,
    S_HOLD   = 5'b01000,
    S_FORGET = 5'b10000
  } state_e;

endpackage

// File: rtl/control_unit.sv
// Top-level sequencer: clears the AG and ALU after reset, streams N_READS read
// strobes, then idles until a forget rising edge restarts a pass.
module control_unit
  import nn_pkg::*;
#(
  parameter int N_READS = N_READS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic forget,
  output logic AG_rst,
  output logic AG_read,
  output logic ALU_rst,
  output logic ALU_forget
);

  localparam int                CNT_W    = $clog2(N_READS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_READS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              forget_q;
  logic              forget_rise;

  // forget_q clears on reset, so a level held through reset release reads as a rise.
  assign forget_rise = forget & ~forget_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_RST;
      cnt_q    <= '0;
      forget_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      forget_q <= forget;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RST: state_d = S_CLR;
      S_CLR: begin
        state_d = S_READ;
        cnt_d   = '0;
      end
      S_READ: begin
        if (forget_rise) begin
          state_d = S_FORGET;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (forget_rise) state_d = S_FORGET;
      end
      S_FORGET: begin
        state_d = S_READ;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore decode straight off the state register; illegal encodings drive the
  // same clears as S_RST while they recover on the next edge.
  always_comb begin
    AG_rst     = 1'b0;
    AG_read    = 1'b0;
    ALU_rst    = 1'b0;
    ALU_forget = 1'b0;
    case (state_q)
      S_CLR: begin
        AG_rst  = 1'b1;
        ALU_rst = 1'b1;
      end
      S_READ: AG_read = 1'b1;
      S_HOLD: ;
      S_FORGET: begin
        AG_rst     = 1'b1;
        ALU_forget = 1'b1;
      end
      default: begin
        AG_rst  = 1'b1;
        ALU_rst = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed reset/forget scenarios followed
// by random forget toggling and reset pulses, compared against a pass-level model.
module tb_control_unit;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic forget = 1'b0;
  logic AG_rst, AG_read, ALU_rst, ALU_forget;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which clearing phase we are in, and how many reads of the pass remain.
  bit m_rst_phase, m_clear, m_forget, m_prev_f;
  int m_reads_left;
  int run_len;
  bit prev_read;

  control_unit #(.N_READS(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .forget     (forget),
    .AG_rst     (AG_rst),
    .AG_read    (AG_read),
    .ALU_rst    (ALU_rst),
    .ALU_forget (ALU_forget)
  );

  always #2 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rst_phase  = 1'b1;
    m_clear      = 1'b0;
    m_forget     = 1'b0;
    m_prev_f     = 1'b0;
    m_reads_left = 0;
    run_len      = 0;
    prev_read    = 1'b0;
  endtask

  task automatic model_step();
    bit rise;
    if (!reset) begin
      model_reset();
      return;
    end
    rise     = forget && !m_prev_f;
    m_prev_f = forget;
    if (m_rst_phase) begin
      m_rst_phase = 1'b0;
      m_clear     = 1'b1;
    end else if (m_clear) begin
      m_clear      = 1'b0;
      m_reads_left = N;
    end else if (m_forget) begin
      m_forget     = 1'b0;
      m_reads_left = N;
    end else if (rise) begin
      m_forget     = 1'b1;
      m_reads_left = 0;
    end else if (m_reads_left > 0) begin
      m_reads_left--;
    end
  endtask

  task automatic compare_outputs(input string when);
    bit busy;
    busy = m_rst_phase || m_clear || m_forget;
    check({when, "_ag_rst"},     AG_rst,     busy);
    check({when, "_alu_rst"},    ALU_rst,    m_rst_phase || m_clear);
    check({when, "_alu_forget"}, ALU_forget, m_forget);
    check({when, "_ag_read"},    AG_read,    !busy && (m_reads_left > 0));
    check("inv_read_excl", AG_read & (AG_rst | ALU_rst | ALU_forget), 1'b0);
    check("inv_rst_forget", ALU_rst & ALU_forget, 1'b0);
    // A pass that ends by dropping into idle must have delivered exactly N reads.
    if (AG_read) run_len++;
    else begin
      if (prev_read && !AG_rst && !ALU_rst && !ALU_forget)
        check("reads_per_pass", run_len, N);
      run_len = 0;
    end
    prev_read = AG_read;
  endtask

  task automatic cycle(input logic f);
    @(negedge clk);
    compare_outputs("cyc");
    forget = f;
    @(posedge clk);
    model_step();
  endtask

  // Reset low for 5 ns starting 1 ns after a rising edge, spanning one edge.
  task automatic reset_pulse();
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    #1 compare_outputs("async_rst");
    #4 reset = 1'b1;
    @(posedge clk);
    model_step();
  endtask

  initial begin
    model_reset();
    // 1: power-on reset, then clear, 8 reads and idle.
    #1 compare_outputs("por");
    #4 reset = 1'b1;
    @(posedge clk);
    model_step();
    for (int i = 0; i < 14; i++) cycle(1'b0);

    // 2: reset pulse mid-pass after three reads, pass restarts in full.
    reset_pulse();
    for (int i = 0; i < 20 && m_reads_left != N - 3; i++) cycle(1'b0);
    reset_pulse();
    for (int i = 0; i < 14; i++) cycle(1'b0);

    // 3: forget held high for 10 cycles in idle gives one forget pass.
    for (int i = 0; i < 10; i++) cycle(1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0);

    // 4: forget rising at the fourth read aborts and restarts the pass.
    reset_pulse();
    for (int i = 0; i < 20 && m_reads_left != N - 3; i++) cycle(1'b0);
    cycle(1'b1);
    cycle(1'b1);
    for (int i = 0; i < 14; i++) cycle(1'b0);

    // 5: forget rising while clearing is ignored and not queued.
    reset_pulse();
    for (int i = 0; i < 14; i++) cycle(1'b1);
    cycle(1'b0);

    // Random forget activity with occasional reset pulses.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) reset_pulse();
      else if ($urandom_range(0, 7) == 0) cycle(~forget);
      else cycle(forget);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
